seven_segment_capture: RTL and testbench

Reverse path of the board's hex-to-seven-segment drive. The block watches a multiplexed, active-low seven-segment bus (digit anodes plus segment lines), qualifies each digit's pattern for stability, and decodes it back to a hex nibble plus a decimal-point flag. When every digit has been captured once, it emits the whole frame over a valid/ready handshake. It is used for display self-check and for sniffing external display panels.

---
 rtl/seven_seg_pkg.sv | 47 ++++
 rtl/seven_segment_pattern_to_hex.sv | 43 ++++
 rtl/seven_segment_capture.sv | 197 +++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// seven_seg_pkg
// Shared segment patterns, decoded-digit type and capture FSM states.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  // The display bus is active-low: a driven 0 lights a segment or enables an anode.
  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  // Segment patterns, bit order a b c d e f g (MSB = a).
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       err;
  } digit_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_CAPTURED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seven_segment_pattern_to_hex.sv
// ============================================================================
// seven_segment_pattern_to_hex
// Combinational decode of an active-low segment pattern to nibble/dp/err.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_pattern_to_hex
  import seven_seg_pkg::*;
(
  input  logic [7:0] i_sseg,
  output digit_t     o_digit
);

  always_comb begin
    o_digit.nibble = 4'h0;
    o_digit.dp     = (i_sseg[7] == SEG_ON);
    o_digit.err    = 1'b0;
    case (i_sseg[6:0])
      SEG_0:     o_digit.nibble = 4'h0;
      SEG_1:     o_digit.nibble = 4'h1;
      SEG_2:     o_digit.nibble = 4'h2;
      SEG_3:     o_digit.nibble = 4'h3;
      SEG_4:     o_digit.nibble = 4'h4;
      SEG_5:     o_digit.nibble = 4'h5;
      SEG_6:     o_digit.nibble = 4'h6;
      SEG_7:     o_digit.nibble = 4'h7;
      SEG_8:     o_digit.nibble = 4'h8;
      SEG_9:     o_digit.nibble = 4'h9;
      SEG_A:     o_digit.nibble = 4'hA;
      SEG_B:     o_digit.nibble = 4'hB;
      SEG_C:     o_digit.nibble = 4'hC;
      SEG_D:     o_digit.nibble = 4'hD;
      SEG_E:     o_digit.nibble = 4'hE;
      SEG_F:     o_digit.nibble = 4'hF;
      SEG_BLANK: o_digit.err    = 1'b1;
      default:   o_digit.err    = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_capture.sv
// ============================================================================
// seven_segment_capture
// Sniffs a multiplexed active-low 7-seg bus, qualifies and decodes each digit,
// and emits a complete frame over a valid/ready handshake.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [7:0]              sseg,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int         IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int         LOW_W   = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2, r_lat_an;
  logic [7:0]              r_sseg_s1, r_sseg_s2, r_lat_sseg;
  logic [IDX_W-1:0]        r_lat_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_DIGITS-1:0]   r_seen;
  digit_t                  r_slot [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] r_hex_out;
  logic [NUM_DIGITS-1:0]   r_dp_out, r_err_out;
  logic                    r_frame_valid, r_overrun;
  state_t                  r_state;

  state_t                  w_state_nxt;
  logic [LOW_W-1:0]        w_low_cnt;
  logic [IDX_W-1:0]        w_sel_idx;
  logic                    w_valid_sel, w_match;
  logic                    w_relatch, w_cnt_inc, w_accept;
  logic [NUM_DIGITS-1:0]   w_accept_mask;
  logic                    w_complete, w_out_free;
  digit_t                  w_dec;

  // Synchronizer idles at all ones so a reset looks like a dark display.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_an_s1   <= '1;
      r_an_s2   <= '1;
      r_sseg_s1 <= '1;
      r_sseg_s2 <= '1;
    end else begin
      r_an_s1   <= an;
      r_an_s2   <= r_an_s1;
      r_sseg_s1 <= sseg;
      r_sseg_s2 <= r_sseg_s1;
    end
  end

  always_comb begin
    w_low_cnt = '0;
    w_sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_an_s2[i] == SEG_ON) begin
        w_low_cnt = w_low_cnt + LOW_W'(1);
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  assign w_valid_sel = (w_low_cnt == LOW_W'(1));
  assign w_match     = (r_an_s2 == r_lat_an) && (r_sseg_s2 == r_lat_sseg);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_relatch   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid_sel) begin
          w_relatch   = 1'b1;
          w_state_nxt = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (w_match) begin
          if (r_cnt == CNT_MAX) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_CAPTURED;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end else if (w_valid_sel) begin
          w_relatch = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURED: begin
        if (!w_match) begin
          if (w_valid_sel) begin
            w_relatch   = 1'b1;
            w_state_nxt = ST_QUALIFY;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lat_an   <= '1;
      r_lat_sseg <= '1;
      r_lat_idx  <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_relatch) begin
        r_lat_an   <= r_an_s2;
        r_lat_sseg <= r_sseg_s2;
        r_lat_idx  <= w_sel_idx;
        r_cnt      <= '0;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  seven_segment_pattern_to_hex u_decode (
    .i_sseg  (r_lat_sseg),
    .o_digit (w_dec)
  );

  always_comb begin
    w_accept_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_accept && (r_lat_idx == IDX_W'(i))) w_accept_mask[i] = 1'b1;
    end
  end

  assign w_complete = &r_seen;
  assign w_out_free = !r_frame_valid || frame_ready;

  // A completed frame is only ever offered once; if the output is still
  // occupied it is dropped and flagged rather than stalling capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_seen        <= '0;
      r_hex_out     <= '0;
      r_dp_out      <= '0;
      r_err_out     <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_slot[i] <= '0;
    end else begin
      r_seen <= (w_complete ? '0 : r_seen) | w_accept_mask;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_accept_mask[i]) r_slot[i] <= w_dec;
      end
      if (w_complete && w_out_free) begin
        r_frame_valid <= 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          r_hex_out[4*i +: 4] <= r_slot[i].nibble;
          r_dp_out[i]         <= r_slot[i].dp;
          r_err_out[i]        <= r_slot[i].err;
        end
      end else begin
        if (w_complete) r_overrun <= 1'b1;
        if (r_frame_valid && frame_ready) r_frame_valid <= 1'b0;
      end
    end
  end

  assign hex_out     = r_hex_out;
  assign dp_out      = r_dp_out;
  assign err_out     = r_err_out;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
// ============================================================================
// tb_seven_segment_capture
// Scoreboard bench: a table-driven display model predicts frames, a monitor
// compares each handshaken frame against the predicted queue.
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seven_segment_capture;

  localparam int ND    = 4;
  localparam int CAP_N = 20;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [7:0]  sseg = 8'hFF;
  logic [15:0] hex_out;
  logic [3:0]  dp_out, err_out;
  logic        frame_valid, overrun;
  logic        frame_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int n_push = 0;
  int n_pop  = 0;

  frame_t exp_q[$];

  logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [3:0] m_nib [ND];
  logic       m_dp  [ND];
  logic       m_err [ND];
  logic [3:0] m_seen = '0;
  bit         ready_mode = 1'b1;
  bit         m_held = 1'b0;
  bit         m_overrun = 1'b0;

  always #5 clk = ~clk;

  seven_segment_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .an          (an),
    .sseg        (sseg),
    .hex_out     (hex_out),
    .dp_out      (dp_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [7:0] s, output logic [3:0] nib,
                                     output logic dp, output logic err);
    nib = 4'h0;
    err = 1'b1;
    dp  = ~s[7];
    for (int k = 0; k < 16; k++) begin
      if (tbl[k] == s[6:0]) begin
        nib = 4'(k);
        err = 1'b0;
      end
    end
  endfunction

  task automatic model_capture(input int d, input logic [7:0] s);
    frame_t f;
    ref_decode(s, m_nib[d], m_dp[d], m_err[d]);
    m_seen[d] = 1'b1;
    if (m_seen == 4'hF) begin
      m_seen = '0;
      for (int i = 0; i < ND; i++) begin
        f.hex[4*i +: 4] = m_nib[i];
        f.dp[i]         = m_dp[i];
        f.err[i]        = m_err[i];
      end
      if (ready_mode || !m_held) begin
        exp_q.push_back(f);
        n_push++;
        if (!ready_mode) m_held = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  // Holds of CAP_N or more cycles are long enough to be accepted; shorter ones are not.
  task automatic drive(input int d, input logic [7:0] s, input int n);
    if (n >= CAP_N) model_capture(d, s);
    an   = ~(4'b0001 << d);
    sseg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    an   = 4'hF;
    sseg = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got hex=%h dp=%b err=%b expected no frame",
                 hex_out, dp_out, err_out);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        n_pop++;
        check("frame_hex", 32'(hex_out), 32'(f.hex));
        check("frame_dp",  32'(dp_out),  32'(f.dp));
        check("frame_err", 32'(err_out), 32'(f.err));
      end
    end
  end

  initial begin
    logic [7:0] s;
    int         idx;
    int         wait_cnt;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_valid",   32'(frame_valid), 32'd0);
    check("reset_hex",     32'(hex_out),     32'd0);
    check("reset_dp_err",  32'({dp_out, err_out}), 32'd0);
    check("reset_overrun", 32'(overrun),     32'd0);
    idle(4);

    // Known frame 0FA2 with the decimal point on digit 1.
    drive(0, {1'b1, 7'b0010010}, CAP_N);
    drive(1, {1'b0, 7'b0001000}, CAP_N);
    drive(2, {1'b1, 7'b0111000}, CAP_N);
    drive(3, {1'b1, 7'b0000001}, CAP_N);
    check("t1_valid", 32'(frame_valid), 32'd1);
    check("t1_hex",   32'(hex_out),     32'h0FA2);
    check("t1_dp",    32'(dp_out),      32'b0010);
    check("t1_err",   32'(err_out),     32'd0);
    idle(4);

    // Digit 2 held too briefly: the frame must wait for a real capture of it.
    drive(0, {1'b1, tbl[1]}, CAP_N);
    drive(1, {1'b1, tbl[3]}, CAP_N);
    drive(2, {1'b1, tbl[5]}, 10);
    drive(3, {1'b1, tbl[7]}, CAP_N);
    idle(10);
    check("t2_no_frame", 32'(n_pop), 32'd1);
    drive(2, {1'b0, tbl[9]}, CAP_N);
    idle(4);

    // Blank digit decodes as an error with a zero nibble.
    drive(0, {1'b1, tbl[4]}, CAP_N);
    drive(1, {1'b1, tbl[6]}, CAP_N);
    drive(2, {1'b1, tbl[8]}, CAP_N);
    drive(3, 8'hFF, CAP_N);
    check("t3_err", 32'(err_out), 32'b1000);
    check("t3_nib3", 32'(hex_out[15:12]), 32'd0);
    idle(4);

    // Consumer stalled across two frames: first held, second dropped.
    ready_mode  = 1'b0;
    frame_ready = 1'b0;
    drive(0, {1'b1, tbl[10]}, CAP_N);
    drive(1, {1'b1, tbl[11]}, CAP_N);
    drive(2, {1'b0, tbl[12]}, CAP_N);
    drive(3, {1'b1, tbl[13]}, CAP_N);
    drive(0, {1'b1, tbl[14]}, CAP_N);
    drive(1, {1'b1, tbl[15]}, CAP_N);
    drive(2, {1'b1, tbl[2]},  CAP_N);
    drive(3, {1'b1, tbl[0]},  CAP_N);
    idle(3);
    check("t4_overrun", 32'(overrun),     32'(m_overrun));
    check("t4_held",    32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    m_held      = 1'b0;
    check("t4_dropped",     32'(frame_valid), 32'd0);
    check("t4_overrun_stk", 32'(overrun),     32'd1);
    ready_mode  = 1'b1;
    frame_ready = 1'b1;
    idle(4);

    // Two low anodes is not a digit; the frame completes only via real captures.
    drive(0, {1'b1, tbl[3]}, CAP_N);
    drive(1, {1'b1, tbl[1]}, CAP_N);
    an   = 4'b1100;
    sseg = {1'b1, tbl[8]};
    repeat (40) @(posedge clk);
    #1;
    check("t5_no_frame", 32'(n_pop), 32'(n_push - 0));
    drive(2, {1'b1, tbl[2]}, CAP_N);
    drive(3, {1'b1, tbl[6]}, CAP_N);
    idle(4);

    // Reset mid-frame discards the partial capture.
    drive(0, {1'b1, tbl[7]}, CAP_N);
    drive(1, {1'b1, tbl[9]}, CAP_N);
    idle(2);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    m_seen    = '0;
    m_overrun = 1'b0;
    check("t6_reset_hex",     32'(hex_out), 32'd0);
    check("t6_reset_overrun", 32'(overrun), 32'd0);
    idle(4);
    drive(0, {1'b0, tbl[12]}, CAP_N);
    drive(1, {1'b1, tbl[13]}, CAP_N);
    drive(2, {1'b1, tbl[14]}, CAP_N);
    drive(3, {1'b1, tbl[15]}, CAP_N);
    idle(4);
    check("t6_overrun", 32'(overrun), 32'(m_overrun));

    // Randomized frames, occasionally preceded by a too-short glitch pattern.
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < ND; d++) begin
        idx = int'($urandom_range(0, 19));
        if (idx < 16) s[6:0] = tbl[idx];
        else          s[6:0] = 7'($urandom);
        s[7] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) drive(d, s ^ 8'h01, int'($urandom_range(3, 12)));
        drive(d, s, CAP_N);
      end
    end
    idle(4);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("frame_count",    32'(n_pop),        32'(n_push));
    check("final_overrun",  32'(overrun),      32'(m_overrun));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
